// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO drain-side serial transmitter.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W = 4;
  localparam int unsigned DATA_BITS   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  // Parity bit for a nibble: even parity when odd_i=0, odd parity when odd_i=1.
  function automatic logic nibble_parity(input logic [FIFO_DATA_W-1:0] data_i,
                                         input logic                   odd_i);
    return (^data_i) ^ odd_i;
  endfunction

endpackage

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and wraps, flags the last and
// second-to-last cycle of each serial bit.
module tx_bit_timer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  output logic bit_end_o,
  output logic bit_pre_end_o
);

  localparam int unsigned CntW = $clog2(BIT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(BIT_CYCLES - 1);
  localparam logic [CntW-1:0] PreCnt  = CntW'(BIT_CYCLES - 2);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_end_o     = (cnt_q == LastCnt);
  assign bit_pre_end_o = (cnt_q == PreCnt);

  // Next count: clear wins, otherwise advance while enabled and wrap at the bit end.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = bit_end_o ? '0 : cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Drains nibbles from a first-word-fall-through FIFO and sends each one as a
// serial frame: start, 4 data bits LSB first, optional parity, stop.
module fifo_serial_tx
  import fifo_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   tx_enable_i,
  input  logic                   fifo_empty_i,
  input  logic [FIFO_DATA_W-1:0] fifo_read_data_i,
  output logic                   fifo_read_en_o,
  output logic                   tx_serial_o,
  output logic                   tx_busy_o,
  output logic                   frame_done_o
);

  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
  localparam logic ParityOdd = (PARITY_ODD != 0);

  tx_state_t              state_q;
  logic [FIFO_DATA_W-1:0] shift_q;
  logic [IdxW-1:0]        idx_q;
  logic                   parity_q;
  logic                   tx_serial_q;
  logic                   busy_q;
  logic                   done_q;

  logic bit_end;
  logic bit_pre_end;
  logic pop;

  // Pop from idle, or in the last stop cycle so frames run back to back.
  // Gated by reset so the FIFO never loses a word while we are held in reset.
  assign pop = rst_ni && tx_enable_i && !fifo_empty_i &&
               ((state_q == StIdle) || ((state_q == StStop) && bit_end));

  assign fifo_read_en_o = pop;
  assign tx_serial_o    = tx_serial_q;
  assign tx_busy_o      = busy_q;
  assign frame_done_o   = done_q;

  tx_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (state_q != StIdle),
    .clear_i      (pop),
    .bit_end_o    (bit_end),
    .bit_pre_end_o(bit_pre_end)
  );

  // Frame sequencer; the line level is registered alongside the state it belongs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      idx_q       <= '0;
      parity_q    <= 1'b0;
      tx_serial_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q     <= StStart;
            shift_q     <= fifo_read_data_i;
            parity_q    <= nibble_parity(fifo_read_data_i, ParityOdd);
            tx_serial_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            state_q     <= StData;
            idx_q       <= '0;
            tx_serial_q <= shift_q[0];
          end
        end
        StData: begin
          if (bit_end) begin
            shift_q <= shift_q >> 1;
            if (idx_q == LastIdx) begin
              if (PARITY_EN != 0) begin
                state_q     <= StParity;
                tx_serial_q <= parity_q;
              end else begin
                state_q     <= StStop;
                tx_serial_q <= 1'b1;
              end
            end else begin
              idx_q       <= idx_q + IdxW'(1);
              // bit 1 now becomes bit 0 after this shift
              tx_serial_q <= shift_q[1];
            end
          end
        end
        StParity: begin
          if (bit_end) begin
            state_q     <= StStop;
            tx_serial_q <= 1'b1;
          end
        end
        StStop: begin
          // Set one cycle early so the registered pulse lands on the last stop cycle.
          if (bit_pre_end) begin
            done_q <= 1'b1;
          end
          if (bit_end) begin
            if (pop) begin
              state_q     <= StStart;
              shift_q     <= fifo_read_data_i;
              parity_q    <= nibble_parity(fifo_read_data_i, ParityOdd);
              tx_serial_q <= 1'b0;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= StIdle;
          tx_serial_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
Drain side of the 4-bit FIFO. Pops one nibble at a time from the FIFO read port and transmits it bit-serially on a single line: start bit, 4 data bits LSB-first, optional parity bit, stop bit. Each bit is held for BIT_CYCLES clocks. Sits between the FIFO and the off-block serial pin; a downstream receiver can reconstruct the nibble stream.

Parameters:
BIT_CYCLES, 4, clocks per serial bit (≥2)
PARITY_EN, 1, 1 = insert parity bit after data, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  system clock, all logic on posedge
rstN  input  1  asynchronous active-low reset
tx_enable  input  1  permission to start new frames
fifo_empty  input  1  FIFO empty flag
fifo_read_data  input  4  FIFO head word, valid whenever fifo_empty=0 (first-word fall-through)
fifo_read_en  output  1  pop strobe to FIFO, one cycle per nibble
tx_serial  output  1  serial line, idle high
tx_busy  output  1  high while a frame is in progress (any state except IDLE)
frame_done  output  1  one-cycle pulse in last cycle of STOP

Behaviour:
- Reset (async, rstN=0): state=IDLE, tx_serial=1, tx_busy=0, frame_done=0, bit counter=0, shift reg=0. fifo_read_en=0 while in reset.
- States: IDLE, START, DATA, PARITY, STOP.
- Pop rule: fifo_read_en = tx_enable && !fifo_empty && (state==IDLE || last cycle of STOP). Combinational (Mealy). Data sampled from fifo_read_data the same cycle. fifo_read_en is never asserted when fifo_empty=1; no reliance on FIFO write/read bypass.
- On pop: nibble latched into shift reg, parity bit computed (XOR of nibble, XOR PARITY_ODD), next state START, bit counter=0.
- tx_serial is registered and reflects the current state: START=0, DATA=shift_reg[0], PARITY=parity bit, STOP=1, IDLE=1.
- The first START cycle is the cycle after the pop.
- Each state lasts exactly BIT_CYCLES clocks. The bit counter counts 0..BIT_CYCLES-1 and wraps.
- DATA lasts 4 bit-periods. The shift reg shifts right at each bit-period end. The data index counts 0..3.
- Transitions:
  - START→DATA
  - DATA (after bit 3)→PARITY if PARITY_EN, else STOP
  - PARITY→STOP
  - STOP→START if a pop occurs in its last cycle (back-to-back, no idle gap), else IDLE
- Frame length: (6+PARITY_EN)*BIT_CYCLES clocks.
- frame_done pulses in the last STOP cycle, regardless of the next pop.
- tx_enable deasserted mid-frame: current frame completes; no further pops.
- fifo_empty rising mid-frame: no effect on the current frame.
- Reset mid-frame: line returns high immediately; the popped nibble is discarded (not re-pushed).
- Counter width $clog2(BIT_CYCLES); no other arithmetic.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_DATA_W=4
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - DATA_BITS=4
- One sub-module: tx_bit_timer (BIT_CYCLES counter with clear input and bit_end output), instantiated once.

Test Plan:
1. Reset held, then released with FIFO empty and tx_enable=1 → tx_serial=1, tx_busy=0, fifo_read_en never asserted for 50 cycles.
2. Single nibble 4'b1011, BIT_CYCLES=4, even parity → one-cycle fifo_read_en. Line then reads 0,1,1,0,1,1(parity),1(stop), 4 clocks each, 28 cycles total. frame_done pulses at cycle 28. Returns to IDLE.
3. PARITY_EN=0, nibbles 4'h0 then 4'hF queued → two back-to-back 24-cycle frames with no idle cycle between. Second pop occurs in the last STOP cycle of frame 1. Line reads 0,0,0,0,0,1 then 0,1,1,1,1,1.
4. PARITY_ODD=1, nibble 4'h3 → parity bit=1. Nibble 4'h7 → parity bit=0.
5. tx_enable dropped during DATA of frame 1 with 3 nibbles queued → frame 1 completes, no further pop, 2 nibbles remain (fifo_empty stays 0).
6. rstN pulsed low mid-DATA → tx_serial=1 asynchronously, state IDLE. After release, the next queued nibble transmits from START correctly.
